ebpf_fetch_unit: RTL
====================

Name: ebpf_fetch_unit

Overview:
- Instruction fetch stage of the eBPF core. Sits between instruction memory and the PC register / decode.
- Owns the sequential fetch pointer and reads 64-bit eBPF instruction slots from IMEM.
- Joins the two slots of LDDW (opcode 0x18) into one decoded item and buffers fetched instructions in a small FIFO for decode.
- Exports the next PC to the PC register stage.

Parameters:
- ADDR_W, 16, IMEM address width in 8-byte instruction slots.
- FIFO_DEPTH, 2, output buffer entries (power of two, >=2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin fetching at start_pc (honoured only in IDLE)
- start_pc  in  64  initial slot index
- redirect  in  1  pulse: branch/jump taken, flush and refetch
- redirect_pc  in  64  target slot index
- imem_req  out  1  read request
- imem_addr  out  ADDR_W  slot address, equal to pc[ADDR_W-1:0]
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  64  instruction slot
- insn_valid  out  1  FIFO head valid
- insn_ready  in  1  decode accepts the head
- insn  out  64  instruction (LDDW: first slot)
- insn_imm_hi  out  32  LDDW second-slot imm (bits 63:32); 0 otherwise
- insn_pc  out  64  slot index of the instruction
- fetch_pc  out  64  current fetch pointer, fed to the PC register
- halted  out  1  EXIT (opcode 0x95) fetched

Behaviour:
- Clocking and reset: all state is clocked on posedge clk. Reset is asynchronous and active-low.
  - On reset: state=IDLE; FIFO empty; lddw_pend=0; drop=0.
  - All outputs are 0: imem_req, imem_addr, insn_valid, insn, insn_imm_hi, insn_pc, fetch_pc, halted.
- States: IDLE, REQ, WAIT, HALTED.
- IDLE:
  - start=1 -> pc<=start_pc, halted<=0, go to REQ.
- REQ:
  - imem_req=1 only when FIFO count < FIFO_DEPTH, counting the pop in the same cycle.
  - imem_gnt=1 -> go to WAIT.
  - At most one request is outstanding.
- WAIT, on imem_rvalid:
  - drop=1 -> discard the data, clear drop, go to REQ.
  - lddw_pend=0 and rdata[7:0]==0x18 -> latch the slot, lddw_pend<=1, pc<=pc+1, go to REQ. Nothing is pushed.
  - lddw_pend=1 -> push {latched slot, rdata[63:32], pc-1}, lddw_pend<=0, pc<=pc+1, go to REQ.
  - Otherwise -> push {rdata, 0, pc}, pc<=pc+1. Go to HALTED if rdata[7:0]==0x95 (halted<=1), else to REQ.
- HALTED: no requests are issued. Only redirect or reset leaves this state.
- Redirect (any state except IDLE):
  - pc<=redirect_pc; FIFO flushed; lddw_pend<=0; halted<=0; go to REQ.
  - If a request is outstanding (in WAIT, or REQ with imem_gnt this cycle): drop<=1, go to WAIT.
  - Redirect has priority over rvalid, push, and start in the same cycle.
  - If a pop and a redirect occur in the same cycle, the pop is lost. Decode must ignore the popped item.
- FIFO:
  - insn/insn_imm_hi/insn_pc reflect the head with no added latency.
  - Pop when insn_valid && insn_ready.
  - Push and pop in the same cycle are allowed at any count.
  - The request gating above guarantees no overflow.
- Arithmetic and latency:
  - pc is 64-bit and wraps modulo 2^64. imem_addr truncates to ADDR_W bits.
  - fetch_pc = pc, registered.
  - Minimum latency from imem_rvalid to insn_valid is 1 cycle.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined: extra port stall_cnt (out, 32).
  - Counts cycles where insn_valid=1 && insn_ready=0, saturating at 0xFFFF_FFFF.
  - Cleared by reset and by start.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Sequential fetch: start_pc=0x10, IMEM gnt the same cycle and rvalid 1 cycle later, slots 0x10..0x12 = ALU ops, insn_ready=1 -> insn_pc 0x10,0x11,0x12 in order; fetch_pc ends at 0x13.
- LDDW join: slot 0x20 = 0x0000_0000_0000_0018, slot 0x21 = 0xDEAD_BEEF_0000_0000 -> one item with insn_pc=0x20 and insn_imm_hi=0xDEADBEEF; next item has insn_pc=0x22.
- Backpressure: insn_ready=0 for 10 cycles -> exactly FIFO_DEPTH items are buffered and imem_req=0; on release all items drain in order, with none lost or duplicated.
- Redirect with request in flight: redirect_pc=0x40 asserted in WAIT -> stale rvalid data is dropped; next pushed item has insn_pc=0x40; FIFO is empty immediately after the redirect.
- EXIT: slot 0x05 = 0x95 -> halted=1 and no further imem_req. A later redirect to 0x00 clears halted and fetching resumes at 0x00.
- Reset mid-WAIT: rst_n low asynchronously -> all outputs 0 the same cycle. After release, only start resumes fetching.

Source files
------------

// File: rtl/ebpf_fetch_if.sv
// eBPF fetch bus: IMEM request/response plus decode handshake.
// master = fetch unit side, slave = IMEM/decode side.
interface ebpf_fetch_if #(
  parameter int ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [63:0]       imem_rdata;
  logic              insn_valid;
  logic              insn_ready;
  logic [63:0]       insn;
  logic [31:0]       insn_imm_hi;
  logic [63:0]       insn_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output insn_valid, insn, insn_imm_hi, insn_pc,
    input  insn_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  insn_valid, insn, insn_imm_hi, insn_pc,
    output insn_ready
  );
endinterface

// File: rtl/ebpf_fetch_unit.sv
// eBPF fetch stage: sequential fetch, LDDW join, output FIFO.
// FETCH_STALL_CNT_EN adds a saturating decode-stall counter port.
module ebpf_fetch_unit #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] start_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  ebpf_fetch_if.master bus,
  output logic [63:0] fetch_pc,
  output logic        halted
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_HALTED
  } state_t;

  typedef struct packed {
    logic [63:0] insn;
    logic [31:0] imm_hi;
    logic [63:0] pc;
  } entry_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] slot, slot_n;
  logic        lddw_pend, lddw_n;
  logic        drop, drop_n;
  logic        halted_n;
  logic        push, pop, flush;
  entry_t      push_e;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic is_lddw, is_exit, in_flight;

  assign bus.insn_valid  = (count != '0);
  assign bus.insn        = mem[rd_ptr].insn;
  assign bus.insn_imm_hi = mem[rd_ptr].imm_hi;
  assign bus.insn_pc     = mem[rd_ptr].pc;
  assign pop = bus.insn_valid && bus.insn_ready;

  // A same-cycle pop frees a slot for the next request.
  assign bus.imem_req = (state == S_REQ) &&
    ((count - CW'(pop)) < CW'(FIFO_DEPTH));
  assign bus.imem_addr = pc[ADDR_W-1:0];
  assign fetch_pc = pc;

  assign is_lddw = (bus.imem_rdata[7:0] == 8'h18);
  assign is_exit = (bus.imem_rdata[7:0] == 8'h95);
  assign in_flight =
    ((state == S_WAIT) && !bus.imem_rvalid) ||
    ((state == S_REQ) && bus.imem_req && bus.imem_gnt);

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    slot_n   = slot;
    lddw_n   = lddw_pend;
    drop_n   = drop;
    halted_n = halted;
    push     = 1'b0;
    push_e   = '0;
    flush    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          pc_n     = start_pc;
          halted_n = 1'b0;
          state_n  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.imem_req && bus.imem_gnt)
          state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          state_n = S_REQ;
          unique case (1'b1)
            drop: drop_n = 1'b0;
            !drop && lddw_pend: begin
              push   = 1'b1;
              push_e = '{slot, bus.imem_rdata[63:32],
                         pc - 64'd1};
              lddw_n = 1'b0;
              pc_n   = pc + 64'd1;
            end
            !drop && !lddw_pend && is_lddw: begin
              slot_n = bus.imem_rdata;
              lddw_n = 1'b1;
              pc_n   = pc + 64'd1;
            end
            default: begin
              push   = 1'b1;
              push_e = '{bus.imem_rdata, 32'h0, pc};
              pc_n   = pc + 64'd1;
              if (is_exit) begin
                halted_n = 1'b1;
                state_n  = S_HALTED;
              end
            end
          endcase
        end
      end
      S_HALTED: ;
      default: state_n = S_IDLE;
    endcase
    // Redirect overrides everything; a live request becomes a drop.
    if (redirect && state != S_IDLE) begin
      pc_n     = redirect_pc;
      flush    = 1'b1;
      push     = 1'b0;
      lddw_n   = 1'b0;
      halted_n = 1'b0;
      state_n  = S_REQ;
      if (in_flight) begin
        drop_n  = 1'b1;
        state_n = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      slot      <= '0;
      lddw_pend <= 1'b0;
      drop      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      slot      <= slot_n;
      lddw_pend <= lddw_n;
      drop      <= drop_n;
      halted    <= halted_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_e;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == S_IDLE && start)
      stall_cnt <= '0;
    else if (bus.insn_valid && !bus.insn_ready &&
             stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
